// File: rtl/peripheral_bridge_arb_pkg.sv
// Shared constants and state encoding for the peripheral bridge arbiter.
package peripheral_bridge_arb_pkg;

  localparam int PB_ADDR_W  = 9;
  localparam int PB_NADDR_W = 9;
  localparam int PB_BE_W    = 4;
  localparam int PB_DATA_W  = 32;

  typedef enum logic [0:0] {
    PB_IDLE,
    PB_GRANT
  } pb_arb_state_e;

endpackage

// File: rtl/peripheral_bridge_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read.
// Pointers carry an extra MSB so full and empty are distinguishable on wrap.
module peripheral_bridge_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       slave_clk,
  input  logic                       slave_reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge slave_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge slave port among NUM_REQ requesters.
// Define PERIPHERAL_BRIDGE_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
//
// state    | meaning
// PB_IDLE  | no command on the bridge; arbitrate among eligible requesters
// PB_GRANT | requester `grant` drives the bridge until accepted or abandoned
module peripheral_bridge_arbiter
  import peripheral_bridge_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PENDING = 16
) (
  input  logic                            slave_clk,
  input  logic                            slave_reset_n,
  input  logic [NUM_REQ-1:0]              r_read,
  input  logic [NUM_REQ-1:0]              r_write,
  input  logic [NUM_REQ*PB_ADDR_W-1:0]    r_address,
  input  logic [NUM_REQ*PB_NADDR_W-1:0]   r_nativeaddress,
  input  logic [NUM_REQ*PB_BE_W-1:0]      r_byteenable,
  input  logic [NUM_REQ*PB_DATA_W-1:0]    r_writedata,
  output logic [NUM_REQ-1:0]              r_waitrequest,
  output logic [NUM_REQ-1:0]              r_readdatavalid,
  output logic [PB_DATA_W-1:0]            r_readdata,
  output logic                            r_endofpacket,
  output logic                            b_read,
  output logic                            b_write,
  output logic [PB_ADDR_W-1:0]            b_address,
  output logic [PB_NADDR_W-1:0]           b_nativeaddress,
  output logic [PB_BE_W-1:0]              b_byteenable,
  output logic [PB_DATA_W-1:0]            b_writedata,
  input  logic                            b_waitrequest,
  input  logic [PB_DATA_W-1:0]            b_readdata,
  input  logic                            b_readdatavalid,
  input  logic                            b_endofpacket,
  output logic [$clog2(MAX_PENDING):0]    pending_cnt,
  output logic                            err_unexpected_rdv
);

  localparam int GW = $clog2(NUM_REQ);

  pb_arb_state_e     state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [NUM_REQ-1:0] eligible;
  logic              win_valid;
  logic [GW-1:0]     win_idx;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [GW-1:0]     tag_head;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = (r_read[i] | r_write[i]) & (~r_read[i] | ~fifo_full);
  end

  // Scan from the far end down so the nearest eligible index is written last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef PERIPHERAL_BRIDGE_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_idx   = GW'(i);
      end
    end
`else
    for (int j = NUM_REQ; j >= 1; j--) begin
      if (eligible[(int'(last_grant) + j) % NUM_REQ]) begin
        win_valid = 1'b1;
        win_idx   = GW'((int'(last_grant) + j) % NUM_REQ);
      end
    end
`endif
  end

  always_comb begin
    b_read          = 1'b0;
    b_write         = 1'b0;
    b_address       = '0;
    b_nativeaddress = '0;
    b_byteenable    = '0;
    b_writedata     = '0;
    if (state == PB_GRANT) begin
      b_read          = r_read[grant];
      b_write         = r_write[grant];
      b_address       = r_address[int'(grant)*PB_ADDR_W +: PB_ADDR_W];
      b_nativeaddress = r_nativeaddress[int'(grant)*PB_NADDR_W +: PB_NADDR_W];
      b_byteenable    = r_byteenable[int'(grant)*PB_BE_W +: PB_BE_W];
      b_writedata     = r_writedata[int'(grant)*PB_DATA_W +: PB_DATA_W];
    end
  end

  assign accept = (b_read | b_write) & ~b_waitrequest;

  always_comb begin
    r_waitrequest = '1;
    if (accept) r_waitrequest[grant] = 1'b0;
  end

  always_comb begin
    r_readdatavalid = '0;
    if (b_readdatavalid && !fifo_empty) r_readdatavalid[tag_head] = 1'b1;
  end

  assign r_readdata    = b_readdata;
  assign r_endofpacket = b_endofpacket;

  peripheral_bridge_arb_tag_fifo #(
    .WIDTH (GW),
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .slave_clk     (slave_clk),
    .slave_reset_n (slave_reset_n),
    .push          (accept & b_read),
    .pop           (b_readdatavalid),
    .din           (grant),
    .dout          (tag_head),
    .count         (pending_cnt),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state              <= PB_IDLE;
      grant              <= '0;
      last_grant         <= GW'(NUM_REQ - 1);
      err_unexpected_rdv <= 1'b0;
    end else begin
      case (state)
        PB_IDLE: begin
          if (win_valid) begin
            grant <= win_idx;
            state <= PB_GRANT;
          end
        end
        PB_GRANT: begin
          if (accept) begin
            last_grant <= grant;
            state      <= PB_IDLE;
          end else if (!(r_read[grant] | r_write[grant])) begin
            state <= PB_IDLE;
          end
        end
        default: state <= PB_IDLE;
      endcase
      if (b_readdatavalid && fifo_empty) err_unexpected_rdv <= 1'b1;
    end
  end

endmodule
